apb_multi_clk_counter: RTL and testbench



---
 rtl/apb_multi_clk_counter_pkg.sv | 18 +
 rtl/apb_clk_counter_ch.sv | 61 ++++++
 rtl/apb_multi_clk_counter.sv | 69 ++++++
 tb/tb_apb_multi_clk_counter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/apb_multi_clk_counter_pkg.sv
// apb_multi_clk_counter_pkg: channel state encoding, register offsets and control bit positions
package apb_multi_clk_counter_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2} ch_state_e;
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CNT_LO = 2'd2;
   localparam logic [1:0] OFF_CNT_HI = 2'd3;
   localparam logic [31:0] GOFF_GCTRL = 32'h0;
   localparam logic [31:0] GOFF_ID    = 32'h4;
   localparam logic [31:0] GOFF_END   = 32'h8;
   localparam int CTRL_START  = 0;
   localparam int CTRL_STOP   = 1;
   localparam int CTRL_CLEAR  = 2;
   localparam int CTRL_SAT    = 3;
   localparam int STATUS_OVF  = 2;
   localparam int GCTRL_START = 0;
   localparam int GCTRL_STOP  = 1;
endpackage

// File: rtl/apb_clk_counter_ch.sv
// apb_clk_counter_ch: one counter channel with run/hold FSM, wrap/saturate, sticky overflow and upper-word shadow
module apb_clk_counter_ch
   import apb_multi_clk_counter_pkg::*;
#(
   parameter int CNT_W = 48
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic        clear_i,
   input  logic        ovf_clr_i,
   input  logic        sat_wr_i,
   input  logic        sat_i,
   input  logic        lo_rd_i,
   output ch_state_e   state_o,
   output logic        ovf_o,
   output logic        sat_o,
   output logic [31:0] cnt_lo_o,
   output logic [31:0] cnt_hi_o
);
   localparam logic [CNT_W-1:0] MAX = '1;
   ch_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic ovf_q, ovf_d, sat_q, sat_d, run, at_max;
   logic [31:0] shadow_q, shadow_d;
   logic [63:0] cnt_ext;
   assign cnt_ext = 64'(cnt_q);
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         sat_q    <= 1'b0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         sat_q    <= sat_d;
         shadow_q <= shadow_d;
      end
   end
   // a STOP in the same write masks START even when STOP itself has no effect
   always_comb begin
      run      = state_q == ST_RUN;
      at_max   = run && cnt_q == MAX;
      state_d  = clear_i ? ST_IDLE
               : stop_i  ? (run ? ST_HOLD : state_q)
               : (start_i && !run) ? ST_RUN : state_q;
      cnt_d    = clear_i ? '0 : !run ? cnt_q : at_max ? (sat_q ? cnt_q : '0) : cnt_q + CNT_W'(1);
      ovf_d    = clear_i ? 1'b0 : at_max ? 1'b1 : ovf_clr_i ? 1'b0 : ovf_q;
      sat_d    = sat_wr_i ? sat_i : sat_q;
      shadow_d = clear_i ? '0 : lo_rd_i ? cnt_ext[63:32] : shadow_q;
   end
   assign state_o  = state_q;
   assign ovf_o    = ovf_q;
   assign sat_o    = sat_q;
   assign cnt_lo_o = cnt_ext[31:0];
   assign cnt_hi_o = shadow_q;
endmodule

// File: rtl/apb_multi_clk_counter.sv
// apb_multi_clk_counter: zero-wait APB slave with NUM_CH independent p_clk interval counters
module apb_multi_clk_counter
   import apb_multi_clk_counter_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 48
) (
   input  logic        p_clk,
   input  logic        prst,
   input  logic [31:0] p_addr,
   input  logic        p_sel,
   input  logic        p_en,
   input  logic        p_write,
   input  logic [31:0] p_wrdata,
   output logic        p_ready,
   output logic [31:0] p_rdata,
   output logic        p_slverr
);
   localparam logic [31:0] G = 32'(NUM_CH * 16);
   logic acc, in_ch, is_gctrl, is_id, err, wr_ok, rd_ok, g_wr, unused_wr;
   logic [1:0] off;
   logic [31:0] ch_rdata [NUM_CH];
   logic [31:0] rd;
   assign acc      = p_sel && p_en;
   assign in_ch    = p_addr < G;
   assign off      = p_addr[3:2];
   assign is_gctrl = p_addr == G + GOFF_GCTRL;
   assign is_id    = p_addr == G + GOFF_ID;
   assign err      = acc && (p_addr >= G + GOFF_END || p_addr[1:0] != 2'b00
                     || (p_write && ((in_ch && off[1]) || is_id)));
   assign wr_ok    = acc && p_write && !err;
   assign rd_ok    = acc && !p_write && !err;
   assign g_wr     = wr_ok && is_gctrl;
   assign unused_wr = ^p_wrdata[31:4];
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic hit, ctrl_wr, ovf, sat;
      logic [31:0] lo, hi;
      ch_state_e st;
      assign hit     = in_ch && p_addr[6:4] == 3'(c);
      assign ctrl_wr = wr_ok && hit && off == OFF_CTRL;
      apb_clk_counter_ch #(.CNT_W(CNT_W)) u_ch (
         .clk_i    (p_clk),
         .rst_i    (prst),
         .start_i  ((ctrl_wr && p_wrdata[CTRL_START]) || (g_wr && p_wrdata[GCTRL_START])),
         .stop_i   ((ctrl_wr && p_wrdata[CTRL_STOP]) || (g_wr && p_wrdata[GCTRL_STOP])),
         .clear_i  (ctrl_wr && p_wrdata[CTRL_CLEAR]),
         .ovf_clr_i(wr_ok && hit && off == OFF_STATUS && p_wrdata[STATUS_OVF]),
         .sat_wr_i (ctrl_wr),
         .sat_i    (p_wrdata[CTRL_SAT]),
         .lo_rd_i  (rd_ok && hit && off == OFF_CNT_LO),
         .state_o  (st),
         .ovf_o    (ovf),
         .sat_o    (sat),
         .cnt_lo_o (lo),
         .cnt_hi_o (hi)
      );
      assign ch_rdata[c] = !hit ? '0
                         : off == OFF_CTRL   ? {28'd0, sat, 3'd0}
                         : off == OFF_STATUS ? {29'd0, ovf, st}
                         : off == OFF_CNT_LO ? lo : hi;
   end
   always_comb begin
      rd = is_id ? {16'd0, 8'(CNT_W), 8'(NUM_CH)} : '0;
      for (int i = 0; i < NUM_CH; i++) rd = rd | ch_rdata[i];
   end
   assign p_ready  = 1'b1;
   assign p_rdata  = rd_ok ? rd : '0;
   assign p_slverr = err;
endmodule

// File: tb/tb_apb_multi_clk_counter.sv
// tb_apb_multi_clk_counter: directed checks on a default build and an 8-bit, 2-channel build
module tb_apb_multi_clk_counter;
   logic clk = 0, rst = 1;
   logic [31:0] addr = '0, wdata = '0;
   logic en = 0, wr = 0, sel_a = 0, sel_b = 0;
   logic rdy_a, rdy_b, err_a, err_b;
   logic [31:0] rdata_a, rdata_b;
   logic [31:0] d;
   logic e;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   apb_multi_clk_counter dut (
      .p_clk(clk), .prst(rst), .p_addr(addr), .p_sel(sel_a), .p_en(en), .p_write(wr),
      .p_wrdata(wdata), .p_ready(rdy_a), .p_rdata(rdata_a), .p_slverr(err_a));
   apb_multi_clk_counter #(.NUM_CH(2), .CNT_W(8)) dut8 (
      .p_clk(clk), .prst(rst), .p_addr(addr), .p_sel(sel_b), .p_en(en), .p_write(wr),
      .p_wrdata(wdata), .p_ready(rdy_b), .p_rdata(rdata_b), .p_slverr(err_b));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // called at a negedge; returns at the negedge after the commit edge
   task automatic xfer(input bit b, input logic [31:0] a, input bit w, input logic [31:0] wd,
                       output logic [31:0] rdv, output logic ev);
      sel_a = !b; sel_b = b; addr = a; wr = w; wdata = wd; en = 0;
      @(negedge clk);
      en = 1;
      #1;
      rdv = b ? rdata_b : rdata_a;
      ev  = b ? err_b : err_a;
      @(negedge clk);
      sel_a = 0; sel_b = 0; en = 0; wr = 0;
   endtask
   task automatic wrt(input bit b, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] x;
      logic y;
      xfer(b, a, 1, wd, x, y);
      chk("wr_err", 32'(y), 0);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      rst = 0;
      chk("ready", 32'(rdy_a), 1);
      chk("rdata_idle", rdata_a, 0);
      chk("slverr_idle", 32'(err_a), 0);
      xfer(0, 'h44, 0, 0, d, e); chk("id", d, 'h3004);
      for (int i = 0; i < 4; i++) begin
         xfer(0, 32'(i * 16 + 4), 0, 0, d, e); chk("status_rst", d, 0);
      end
      wrt(0, 'h00, 1);
      repeat (10) @(negedge clk);
      wrt(0, 'h00, 2);
      xfer(0, 'h04, 0, 0, d, e); chk("ch0_hold", d, 2);
      xfer(0, 'h08, 0, 0, d, e); chk("ch0_lo", d, 12);
      xfer(0, 'h0C, 0, 0, d, e); chk("ch0_hi", d, 0);
      wrt(0, 'h20, 1);
      repeat (5) @(negedge clk);
      wrt(0, 'h20, 7);
      xfer(0, 'h24, 0, 0, d, e); chk("clr_wins_st", d, 0);
      xfer(0, 'h28, 0, 0, d, e); chk("clr_wins_cnt", d, 0);
      wrt(0, 'h30, 1);
      wrt(0, 'h30, 2);
      xfer(0, 'h38, 0, 0, d, e); chk("b2b", d, 2);
      wrt(0, 'h30, 1);
      repeat (3) @(negedge clk);
      wrt(0, 'h30, 2);
      xfer(0, 'h38, 0, 0, d, e); chk("resume", d, 7);
      for (int i = 0; i < 4; i++) wrt(0, 32'(i * 16), 4);
      wrt(0, 'h40, 1);
      repeat (5) @(negedge clk);
      wrt(0, 'h40, 2);
      for (int i = 0; i < 4; i++) begin
         xfer(0, 32'(i * 16 + 8), 0, 0, d, e); chk("all_cnt", d, 7);
      end
      wrt(0, 'h40, 3);
      xfer(0, 'h14, 0, 0, d, e); chk("stopall_wins", d, 2);
      xfer(0, 'h18, 0, 0, d, e); chk("stopall_cnt", d, 7);
      xfer(0, 'h40, 0, 0, d, e); chk("gctrl_rd", d, 0);
      wrt(0, 'h40, 1);
      xfer(0, 'h08, 0, 0, d, e); chk("lo_live", d, 8);
      repeat (5) @(negedge clk);
      xfer(0, 'h0C, 0, 0, d, e); chk("hi_shadow", d, 0);
      wrt(0, 'h40, 2);
      xfer(0, 'h28, 0, 0, d, e); chk("ch2_cnt", d, 18);
      xfer(0, 'h48, 0, 0, d, e); chk("oob_err", 32'(e), 1); chk("oob_rdata", d, 0);
      xfer(0, 'h02, 0, 0, d, e); chk("misalign_err", 32'(e), 1);
      xfer(0, 'h44, 1, 0, d, e); chk("id_wr_err", 32'(e), 1);
      xfer(0, 'h08, 1, 0, d, e); chk("lo_wr_err", 32'(e), 1);
      xfer(0, 'h01, 1, 4, d, e); chk("mis_clr_err", 32'(e), 1);
      xfer(0, 'h08, 0, 0, d, e); chk("no_side_eff", d, 18);
      xfer(0, 'h44, 0, 0, d, e); chk("id_kept", d, 'h3004);
      wrt(0, 'h40, 1);
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      xfer(0, 'h04, 0, 0, d, e); chk("rst_st", d, 0);
      xfer(0, 'h08, 0, 0, d, e); chk("rst_cnt", d, 0);
      xfer(1, 'h24, 0, 0, d, e); chk("id8", d, 'h0802);
      wrt(1, 'h10, 1);
      repeat (255) @(negedge clk);
      xfer(1, 'h18, 0, 0, d, e); chk("wrap_cnt", d, 0);
      xfer(1, 'h14, 0, 0, d, e); chk("wrap_ovf", d, 5);
      wrt(1, 'h14, 4);
      xfer(1, 'h14, 0, 0, d, e); chk("w1c", d, 1);
      xfer(1, 'h04, 0, 0, d, e); chk("ch0_8_idle", d, 0);
      wrt(1, 'h10, 4);
      wrt(1, 'h10, 9);
      repeat (300) @(negedge clk);
      xfer(1, 'h18, 0, 0, d, e); chk("sat_cnt", d, 'hFF);
      xfer(1, 'h14, 0, 0, d, e); chk("sat_ovf", d, 5);
      wrt(1, 'h14, 4);
      xfer(1, 'h14, 0, 0, d, e); chk("w1c_vs_set", d, 5);
      wrt(1, 'h10, 'hA);
      wrt(1, 'h14, 4);
      xfer(1, 'h14, 0, 0, d, e); chk("hold_w1c", d, 2);
      xfer(1, 'h10, 0, 0, d, e); chk("sat_rd", d, 8);
      xfer(1, 'h18, 0, 0, d, e); chk("sat_held", d, 'hFF);
      xfer(1, 'h1C, 0, 0, d, e); chk("hi8", d, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
